des_block_packer: RTL and testbench
===================================

// Module: des_block_packer
// PURPOSE
//   Upstream feeder for the pipelined des core: packs a byte stream into 64-bit blocks.
//   Latches key/mode per message and applies PKCS#5 padding on the final block.
//   Drives des data_i/valid_i/key_i/mode_i directly; the core has no backpressure, so
//   valid_o is a one-cycle pulse per block.
// PARAMETERS
//   PAD_EN   1   1: PKCS#5 padding (always pads, full 0x08 block if length%8==0);
//                0: zero-fill partial last block, no extra block
// PORTS
//   clk_i         in   1     clock, rising edge
//   reset_i       in   1     asynchronous, active-high reset
//   byte_i        in   8     input byte
//   byte_valid_i  in   1     byte_i valid
//   byte_last_i   in   1     byte_i is the final byte of the message
//   byte_ready_o  out  1     byte accepted when byte_valid_i & byte_ready_o
//   mode_i        in   1     0=encrypt, 1=decrypt; sampled on the first byte of a message
//   key_i         in   64    [0:63] key; sampled on the first byte of a message
//   data_o        out  64    [0:63] packed block; first byte in bits [0:7]
//   valid_o       out  1     one-cycle pulse per block
//   key_o         out  64    message key, stable for every block of the message
//   mode_o        out  1     message mode, stable for every block of the message
//   last_o        out  1     qualifies valid_o: final block of the message
// BEHAVIOUR
//   Reset values: byte_ready_o=0 during reset, 1 after reset; data_o, key_o, valid_o,
//     mode_o, last_o all 0; byte counter 0; state FILL.
//   States: FILL, PAD.
//   FILL: byte_ready_o=1. An accepted byte is written to lane cnt (bits [8*cnt:8*cnt+7]),
//     then cnt increments; cnt is 3 bits and wraps 7->0.
//   First byte of a message (cnt==0 and not in a message): key_i/mode_i are captured into
//     key_o/mode_o in the same cycle. Later key_i/mode_i changes mid-message are ignored.
//   Block emit (8th byte accepted, or last byte accepted):
//     - data_o is registered and valid_o=1 on the next cycle only (latency 1).
//     - data_o and last_o hold until the next emit.
//   Last byte with k=cnt+1 bytes in block, k<8:
//     - PAD_EN=1: lanes k..7 = 8-k.
//     - PAD_EN=0: lanes k..7 = 0x00.
//     - last_o=1; cnt->0; message ends.
//   Last byte completing a block (k=8):
//     - PAD_EN=1: emit the data block with last_o=0, enter PAD; PAD holds byte_ready_o=0
//       for one cycle and emits 0x0808080808080808 with last_o=1 (valid_o in the cycle
//       after the data block), then returns to FILL.
//     - PAD_EN=0: emit the block with last_o=1.
//   Gaps in byte_valid_i: no effect on the result; no timeout.
//   Back-to-back bytes: one full block per 8 cycles; valid_o never asserted 2 cycles
//     running, except the data+pad pair.
//   byte_last_i without byte_valid_i is ignored.
//   Reset mid-message: partial block discarded, no valid_o; the next byte starts a new
//     message.
// STRUCTURE
//   Shared include des_defs.vh:
//     - localparams BLOCK_W=64, BYTE_W=8, LANES=8;
//     - state encodings ST_FILL, ST_PAD.
//   Single module, no sub-module. Padding lane mask/value comes from a function of k.
// TESTING
//   1 PAD_EN=1, bytes 01..08, last on 08 -> 0102030405060708 (last_o=0); next cycle
//     0808080808080808 (last_o=1); byte_ready_o=0 in the PAD cycle.
//   2 PAD_EN=1, bytes AA BB CC, last on CC -> AABBCC0505050505, last_o=1, 1 cycle after CC.
//   3 PAD_EN=0, byte 41 with last -> 4100000000000000, last_o=1; no extra block.
//   4 PAD_EN=1, 16 bytes 00..0F back-to-back, key_i changed after byte 3
//     -> blocks 0001020304050607, 08090A0B0C0D0E0F, 0808080808080808;
//     key_o = key from byte 0 throughout.
//   5 Same bytes as 1 with random byte_valid_i gaps -> identical blocks and last_o.
//   6 Reset asserted after 5 bytes -> no valid_o; then bytes 11..18 with last on 18
//     -> 1112131415161718, then pad block.
//   Bench: chain into des and compare des data_o against expected vectors.

Source files
------------

// File: rtl/des_block_packer_pkg.sv
// Shared constants, state encoding and padding helper for the DES block packer.
// Blocks use DES bit numbering: DES bit 0 is the MSB, so the first byte occupies [63:56].
package des_block_packer_pkg;

    localparam int BLOCK_W = 64;
    localparam int BYTE_W  = 8;
    localparam int LANES   = 8;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PAD  = 1'b1
    } state_t;

    localparam logic [BLOCK_W-1:0] PAD_BLOCK = {LANES{8'h08}};

    // Overwrite lanes k..7 of a block holding k valid bytes (k in 1..7).
    function automatic logic [BLOCK_W-1:0] pad_tail(
        input logic [BLOCK_W-1:0] blk,
        input logic [3:0]         k,
        input logic               pad_en
    );
        logic [BLOCK_W-1:0] res;
        logic [BYTE_W-1:0]  fill;
        res  = blk;
        fill = pad_en ? {4'h0, 4'd8 - k} : '0;
        for (int i = 0; i < LANES; i++) begin
            if (4'(i) >= k) begin
                res[BLOCK_W-1-BYTE_W*i -: BYTE_W] = fill;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/des_block_packer.sv
// Packs a byte stream into 64-bit DES blocks, latching key/mode per message and
// padding the final block. Output is a one-cycle valid pulse per block.
module des_block_packer
    import des_block_packer_pkg::*;
#(
    parameter bit PAD_EN = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [BYTE_W-1:0]  byte_i,
    input  logic               byte_valid_i,
    input  logic               byte_last_i,
    output logic               byte_ready_o,
    input  logic               mode_i,
    input  logic [BLOCK_W-1:0] key_i,
    output logic [BLOCK_W-1:0] data_o,
    output logic               valid_o,
    output logic [BLOCK_W-1:0] key_o,
    output logic               mode_o,
    output logic               last_o
);

    state_t             state_reg, state_next;
    logic [2:0]         cnt_reg, cnt_next;
    logic               in_msg_reg, in_msg_next;
    logic               ready_reg, ready_next;
    logic [BLOCK_W-1:0] buf_reg, buf_next;
    logic [BLOCK_W-1:0] data_reg, data_next;
    logic               valid_reg, valid_next;
    logic               last_reg, last_next;
    logic [BLOCK_W-1:0] key_reg, key_next;
    logic               mode_reg, mode_next;

    logic [BLOCK_W-1:0] cur_block;
    logic [3:0]         k;
    logic               accept;

    // Buffered lanes with the incoming byte dropped into lane cnt.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign cur_block[BLOCK_W-1-BYTE_W*gi -: BYTE_W] =
                (cnt_reg == 3'(gi)) ? byte_i : buf_reg[BLOCK_W-1-BYTE_W*gi -: BYTE_W];
        end
    endgenerate

    assign accept = byte_valid_i & ready_reg;
    assign k      = {1'b0, cnt_reg} + 4'd1;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        in_msg_next = in_msg_reg;
        ready_next  = ready_reg;
        buf_next    = buf_reg;
        data_next   = data_reg;
        valid_next  = 1'b0;
        last_next   = last_reg;
        key_next    = key_reg;
        mode_next   = mode_reg;

        case (state_reg)
            ST_FILL: begin
                ready_next = 1'b1;
                if (accept) begin
                    buf_next    = cur_block;
                    cnt_next    = cnt_reg + 3'd1;
                    in_msg_next = 1'b1;
                    if (!in_msg_reg && cnt_reg == 3'd0) begin
                        key_next  = key_i;
                        mode_next = mode_i;
                    end
                    if (byte_last_i) begin
                        in_msg_next = 1'b0;
                        cnt_next    = 3'd0;
                        valid_next  = 1'b1;
                        if (k == 4'd8) begin
                            data_next = cur_block;
                            if (PAD_EN) begin
                                // Full final block still needs a whole pad block after it.
                                last_next  = 1'b0;
                                state_next = ST_PAD;
                                ready_next = 1'b0;
                            end else begin
                                last_next = 1'b1;
                            end
                        end else begin
                            data_next = pad_tail(cur_block, k, PAD_EN);
                            last_next = 1'b1;
                        end
                    end else if (cnt_reg == 3'd7) begin
                        data_next  = cur_block;
                        valid_next = 1'b1;
                        last_next  = 1'b0;
                    end
                end
            end
            ST_PAD: begin
                data_next  = PAD_BLOCK;
                valid_next = 1'b1;
                last_next  = 1'b1;
                state_next = ST_FILL;
                ready_next = 1'b1;
            end
            default: begin
                state_next = ST_FILL;
                ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg  <= ST_FILL;
            cnt_reg    <= 3'd0;
            in_msg_reg <= 1'b0;
            ready_reg  <= 1'b0;
            buf_reg    <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            last_reg   <= 1'b0;
            key_reg    <= '0;
            mode_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            in_msg_reg <= in_msg_next;
            ready_reg  <= ready_next;
            buf_reg    <= buf_next;
            data_reg   <= data_next;
            valid_reg  <= valid_next;
            last_reg   <= last_next;
            key_reg    <= key_next;
            mode_reg   <= mode_next;
        end
    end

    assign byte_ready_o = ready_reg;
    assign data_o       = data_reg;
    assign valid_o      = valid_reg;
    assign last_o       = last_reg;
    assign key_o        = key_reg;
    assign mode_o       = mode_reg;

endmodule

// File: tb/tb_des_block_packer.sv
// Directed bench: a padding and a zero-fill packer share one byte stream; emitted
// blocks are captured per instance and compared against hand-computed vectors.
module tb_des_block_packer;

    localparam logic [63:0] KA = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] KB = 64'h0E32_9232_EA6D_0D73;
    localparam logic [63:0] KC = 64'hAABB_0918_2736_CCDD;
    localparam logic [63:0] K1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] K2 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] KD = 64'h3B38_98A7_1C3F_B4E2;
    localparam logic [63:0] KE = 64'h1111_2222_3333_4444;
    localparam logic [63:0] KF = 64'h5555_6666_7777_8888;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid_i = 1'b0;
    logic        byte_last_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [63:0] key_i = '0;

    logic        ready_p, valid_p, mode_p, last_p;
    logic [63:0] data_p, key_p;
    logic        ready_n, valid_n, mode_n, last_n;
    logic [63:0] data_n, key_n;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int last_acc = 0;

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          cyc;
        logic [63:0] key;
        logic        mode;
    } blk_t;

    blk_t got_p[$];
    blk_t got_n[$];
    blk_t exp_p[$];
    blk_t exp_n[$];

    des_block_packer #(.PAD_EN(1'b1)) dut_pad (
        .clk_i(clk), .reset_i(reset_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .byte_last_i(byte_last_i), .byte_ready_o(ready_p), .mode_i(mode_i), .key_i(key_i),
        .data_o(data_p), .valid_o(valid_p), .key_o(key_p), .mode_o(mode_p), .last_o(last_p)
    );

    des_block_packer #(.PAD_EN(1'b0)) dut_nopad (
        .clk_i(clk), .reset_i(reset_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .byte_last_i(byte_last_i), .byte_ready_o(ready_n), .mode_i(mode_i), .key_i(key_i),
        .data_o(data_n), .valid_o(valid_n), .key_o(key_n), .mode_o(mode_n), .last_o(last_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        blk_t b;
        if (valid_p) begin
            b.data = data_p; b.last = last_p; b.cyc = cyc; b.key = key_p; b.mode = mode_p;
            got_p.push_back(b);
            $display("blk pad=1 cyc=%0d data=%h last=%0b key=%h mode=%0b",
                     cyc, data_p, last_p, key_p, mode_p);
        end
        if (valid_n) begin
            b.data = data_n; b.last = last_n; b.cyc = cyc; b.key = key_n; b.mode = mode_n;
            got_n.push_back(b);
            $display("blk pad=0 cyc=%0d data=%h last=%0b key=%h mode=%0b",
                     cyc, data_n, last_n, key_n, mode_n);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n, input logic junk_last);
        byte_valid_i = 1'b0;
        byte_last_i  = junk_last;
        repeat (n) @(negedge clk);
        byte_last_i  = 1'b0;
    endtask

    // Presents one byte; returns at the negedge after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b, input logic l);
        bit done;
        done = 1'b0;
        byte_i = b; byte_last_i = l; byte_valid_i = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            if (ready_p) done = 1'b1;
            @(negedge clk);
        end
        if (!done) check_val("send timeout", 64'd0, 64'd1);
        last_acc = cyc;
        $display("byte %h last=%0b accepted cyc=%0d", b, l, cyc);
    endtask

    task automatic exp_add(input bit pad, input logic [63:0] d, input logic l, input int c,
                           input logic [63:0] kv, input logic m);
        blk_t b;
        b.data = d; b.last = l; b.cyc = c; b.key = kv; b.mode = m;
        if (pad) exp_p.push_back(b);
        else     exp_n.push_back(b);
    endtask

    task automatic compare_q(input string tag, input bit pad);
        blk_t g[$];
        blk_t e[$];
        if (pad) begin g = got_p; e = exp_p; end
        else     begin g = got_n; e = exp_n; end
        check_val({tag, " count"}, 64'(g.size()), 64'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < g.size()) begin
                check_val($sformatf("%s blk%0d data", tag, i), g[i].data, e[i].data);
                check_val($sformatf("%s blk%0d last", tag, i), 64'(g[i].last), 64'(e[i].last));
                check_val($sformatf("%s blk%0d key", tag, i), g[i].key, e[i].key);
                check_val($sformatf("%s blk%0d mode", tag, i), 64'(g[i].mode), 64'(e[i].mode));
                if (e[i].cyc >= 0)
                    check_val($sformatf("%s blk%0d cyc", tag, i), 64'(g[i].cyc), 64'(e[i].cyc));
            end
        end
        if (pad) begin got_p.delete(); exp_p.delete(); end
        else     begin got_n.delete(); exp_n.delete(); end
    endtask

    initial begin
        int c7, c15, e1;
        logic [7:0] gaps [8];
        gaps = '{0, 2, 1, 3, 0, 1, 2, 0};

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst ready", 64'(ready_p), 64'd0);
        check_val("rst valid", 64'(valid_p), 64'd0);
        check_val("rst data", data_p, 64'd0);
        check_val("rst key", key_p, 64'd0);
        check_val("rst mode", 64'(mode_p), 64'd0);
        check_val("rst last", 64'(last_p), 64'd0);
        reset_i = 1'b0;
        @(negedge clk);
        check_val("post-rst ready", 64'(ready_p), 64'd1);

        // 1: exact 8-byte message
        key_i = KA; mode_i = 1'b0;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        e1 = last_acc;
        check_val("t1 pad ready in PAD", 64'(ready_p), 64'd0);
        check_val("t1 nopad ready", 64'(ready_n), 64'd1);
        idle(1, 1'b0);
        check_val("t1 pad ready after PAD", 64'(ready_p), 64'd1);
        idle(3, 1'b0);
        exp_add(1, 64'h0102030405060708, 1'b0, e1, KA, 1'b0);
        exp_add(1, 64'h0808080808080808, 1'b1, e1 + 1, KA, 1'b0);
        exp_add(0, 64'h0102030405060708, 1'b1, e1, KA, 1'b0);
        compare_q("t1 pad", 1);
        compare_q("t1 nopad", 0);

        // 2: three-byte message
        key_i = KB; mode_i = 1'b1;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        e1 = last_acc;
        idle(4, 1'b0);
        exp_add(1, 64'hAABBCC0505050505, 1'b1, e1, KB, 1'b1);
        exp_add(0, 64'hAABBCC0000000000, 1'b1, e1, KB, 1'b1);
        compare_q("t2 pad", 1);
        compare_q("t2 nopad", 0);

        // 3: single byte
        key_i = KC; mode_i = 1'b0;
        send_byte(8'h41, 1'b1);
        e1 = last_acc;
        idle(4, 1'b0);
        exp_add(1, 64'h4107070707070707, 1'b1, e1, KC, 1'b0);
        exp_add(0, 64'h4100000000000000, 1'b1, e1, KC, 1'b0);
        compare_q("t3 pad", 1);
        compare_q("t3 nopad", 0);

        // 4: 16 bytes back-to-back, key/mode changed mid-message
        key_i = K1; mode_i = 1'b0;
        c7 = 0; c15 = 0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), i == 15);
            if (i == 3) begin key_i = K2; mode_i = 1'b1; end
            if (i == 7) c7 = last_acc;
            if (i == 15) c15 = last_acc;
        end
        idle(4, 1'b0);
        check_val("t4 block spacing", 64'(c15 - c7), 64'd8);
        exp_add(1, 64'h0001020304050607, 1'b0, c7, K1, 1'b0);
        exp_add(1, 64'h08090A0B0C0D0E0F, 1'b0, c15, K1, 1'b0);
        exp_add(1, 64'h0808080808080808, 1'b1, c15 + 1, K1, 1'b0);
        exp_add(0, 64'h0001020304050607, 1'b0, c7, K1, 1'b0);
        exp_add(0, 64'h08090A0B0C0D0E0F, 1'b1, c15, K1, 1'b0);
        compare_q("t4 pad", 1);
        compare_q("t4 nopad", 0);

        // 5: same bytes as 1 with gaps; last flag toggled while not valid
        key_i = KD; mode_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            idle(int'(gaps[i-1]), 1'b1);
            send_byte(8'(i), i == 8);
        end
        e1 = last_acc;
        idle(4, 1'b0);
        exp_add(1, 64'h0102030405060708, 1'b0, e1, KD, 1'b1);
        exp_add(1, 64'h0808080808080808, 1'b1, e1 + 1, KD, 1'b1);
        exp_add(0, 64'h0102030405060708, 1'b1, e1, KD, 1'b1);
        compare_q("t5 pad", 1);
        compare_q("t5 nopad", 0);

        // 6: reset after 5 bytes discards the partial block
        key_i = KE; mode_i = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i), 1'b0);
        idle(0, 1'b0);
        reset_i = 1'b1;
        @(negedge clk);
        check_val("t6 rst ready", 64'(ready_p), 64'd0);
        check_val("t6 rst key", key_p, 64'd0);
        reset_i = 1'b0;
        idle(3, 1'b0);
        compare_q("t6 after rst pad", 1);
        compare_q("t6 after rst nopad", 0);
        key_i = KF; mode_i = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i), i == 7);
        e1 = last_acc;
        idle(4, 1'b0);
        exp_add(1, 64'h1112131415161718, 1'b0, e1, KF, 1'b0);
        exp_add(1, 64'h0808080808080808, 1'b1, e1 + 1, KF, 1'b0);
        exp_add(0, 64'h1112131415161718, 1'b1, e1, KF, 1'b0);
        compare_q("t6 pad", 1);
        compare_q("t6 nopad", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
